vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 89 ++++++++
 tb/tb_vga_timing_gen.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel prescaler, h/v counters, active-area decode and
// sync/colour outputs registered one pixel behind x/y to cover the buffer read.
module vga_timing_gen #(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       CLK_IN,
  input  logic       RESET,
  input  logic [7:0] memRGB,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       VIDEO_ON,
  output logic       FRAME_CLOCK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic [7:0] VGA_RGB
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(CLK_DIV - 1);

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_FCL  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [PW-1:0] r_p;
  logic [9:0]    r_h, r_v;
  logic [7:0]    r_rgb;
  logic          r_hs, r_vs, r_fc;
  logic          w_tick, w_active, w_hs_win, w_vs_win;

  assign w_tick   = (r_p == P_MAX);
  assign w_active = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hs_win = (r_h >= HS_BEG) && (r_h <= HS_END);
  assign w_vs_win = (r_v >= VS_BEG) && (r_v <= VS_END);

  assign x           = w_active ? r_h : 10'd0;
  assign y           = w_active ? r_v : 10'd0;
  assign VIDEO_ON    = w_active;
  assign VGA_RGB     = r_rgb;
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign FRAME_CLOCK = r_fc;

  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      r_p   <= '0;
      r_h   <= '0;
      r_v   <= '0;
      r_rgb <= 8'h00;
      r_hs  <= ~SYNC_POL;
      r_vs  <= ~SYNC_POL;
      r_fc  <= 1'b0;
    end else begin
      r_fc <= 1'b0;
      if (w_tick) begin
        r_p <= '0;
        // outputs capture the position being left, so they trail x/y by one pixel
        r_rgb <= w_active ? memRGB : 8'h00;
        r_hs  <= w_hs_win ? SYNC_POL : ~SYNC_POL;
        r_vs  <= w_vs_win ? SYNC_POL : ~SYNC_POL;
        r_fc  <= (r_h == H_LAST) && (r_v == V_FCL);
        if (r_h == H_LAST) begin
          r_h <= '0;
          r_v <= (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
        end else begin
          r_h <= r_h + 10'd1;
        end
      end else begin
        r_p <= r_p + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen at a shrunken raster: closed-form time model plus
// literal checks on latency, sync widths and frame period.
module tb_vga_timing_gen;
  localparam int D = 3;
  localparam int HA = 16, HF = 4, HSW = 5, HB = 3;
  localparam int VA = 12, VF = 2, VSW = 3, VB = 4;
  localparam int HT = HA + HF + HSW + HB;   // 28
  localparam int VT = VA + VF + VSW + VB;   // 21
  localparam int FRAME = HT * VT * D;       // 1764

  logic       CLK_IN = 1'b0;
  logic       RESET  = 1'b1;
  logic [7:0] memRGB = 8'h00;
  logic [9:0] x, y;
  logic       VIDEO_ON, FRAME_CLOCK, VGA_HS, VGA_VS;
  logic [7:0] VGA_RGB;

  vga_timing_gen #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut (
    .CLK_IN(CLK_IN), .RESET(RESET), .memRGB(memRGB), .x(x), .y(y),
    .VIDEO_ON(VIDEO_ON), .FRAME_CLOCK(FRAME_CLOCK), .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS), .VGA_RGB(VGA_RGB)
  );

  always #5 CLK_IN = ~CLK_IN;

  int errors = 0;
  int checks = 0;

  // Model: n = clock edges since the last reset edge; pixel index k = n / D.
  int         n = 0;
  bit         model_ok = 1'b0;
  logic [7:0] rgb_m = 8'h00;
  logic       fc_m = 1'b0;

  function automatic bit pix_active(int k);
    return ((k % HT) < HA) && (((k / HT) % VT) < VA);
  endfunction

  always @(posedge CLK_IN) begin
    if (RESET) begin
      n = 0; rgb_m = 8'h00; fc_m = 1'b0; model_ok = 1'b1;
    end else begin
      n++;
      fc_m = 1'b0;
      if (n % D == 0) begin
        int k0;
        k0 = n / D - 1;
        rgb_m = pix_active(k0) ? memRGB : 8'h00;
        fc_m  = ((k0 % HT) == HT - 1) && (((k0 / HT) % VT) == VA - 1);
      end
    end
  end

  always @(negedge CLK_IN) begin
    if (model_ok) begin
      int k, h, v, hp, vp;
      bit a, hs_e, vs_e;
      logic [32:0] exp_v, act_v;
      k = n / D; h = k % HT; v = (k / HT) % VT;
      a = (h < HA) && (v < VA);
      hs_e = 1'b1; vs_e = 1'b1;
      if (k > 0) begin
        hp = (k - 1) % HT; vp = ((k - 1) / HT) % VT;
        hs_e = !(hp >= HA + HF && hp < HA + HF + HSW);
        vs_e = !(vp >= VA + VF && vp < VA + VF + VSW);
      end
      exp_v = {(a ? 10'(h) : 10'd0), (a ? 10'(v) : 10'd0), a, rgb_m, hs_e, vs_e, fc_m};
      act_v = {x, y, VIDEO_ON, VGA_RGB, VGA_HS, VGA_VS, FRAME_CLOCK};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model n=%0d got x=%0d y=%0d von=%b rgb=%h hs=%b vs=%b fc=%b expected %h/%h",
                 n, x, y, VIDEO_ON, VGA_RGB, VGA_HS, VGA_VS, FRAME_CLOCK, exp_v, act_v);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Release reset with A5 on the bus; x advances and colour appears after D edges.
  task automatic release_check(input string tag);
    memRGB = 8'hA5;
    RESET  = 1'b0;
    for (int c = 1; c <= D; c++) begin
      @(negedge CLK_IN);
      if (c < D) chk({tag, "_x_hold"}, int'(x), 0);
      else begin
        chk({tag, "_x_step"}, int'(x), 1);
        chk({tag, "_rgb_a5"}, int'(VGA_RGB), 8'hA5);
      end
    end
  endtask

  int hs_run = 0, vs_run = 0, hs_len = -1, vs_len = -1;
  int hs_fall[$];
  int fc_t[$];
  logic hs_prev = 1'b1;
  bit found;

  initial begin
    repeat (3) @(negedge CLK_IN);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_von", int'(VIDEO_ON), 1);
    chk("rst_hs", int'(VGA_HS), 1);
    chk("rst_rgb", int'(VGA_RGB), 0);
    release_check("rel1");

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge CLK_IN);
      memRGB = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
      if (VGA_HS == 1'b0) begin
        if (hs_prev) hs_fall.push_back(cyc);
        hs_run++;
      end else if (hs_run > 0) begin
        if (hs_len < 0) hs_len = hs_run;
        hs_run = 0;
      end
      hs_prev = VGA_HS;
      if (VGA_VS == 1'b0) vs_run++;
      else if (vs_run > 0) begin
        if (vs_len < 0) vs_len = vs_run;
        vs_run = 0;
      end
      if (FRAME_CLOCK) fc_t.push_back(cyc);
    end
    chk("hs_low_cycles", hs_len, HSW * D);
    chk("line_period", (hs_fall.size() >= 2) ? hs_fall[1] - hs_fall[0] : -1, HT * D);
    chk("vs_low_cycles", vs_len, VSW * HT * D);
    chk("fc_pulses", fc_t.size(), 2);
    chk("frame_period", (fc_t.size() >= 2) ? fc_t[1] - fc_t[0] : -1, FRAME);

    // mid-frame reset, one cycle into pixel (8,6)
    memRGB = 8'hFF;
    found = 1'b0;
    for (int i = 0; i < FRAME + 10 && !found; i++) begin
      @(negedge CLK_IN);
      if (x == 10'd8 && y == 10'd6) found = 1'b1;
    end
    chk("mid_found", int'(found), 1);
    @(negedge CLK_IN);
    RESET = 1'b1;
    @(negedge CLK_IN);
    chk("mid_x", int'(x), 0);
    chk("mid_von", int'(VIDEO_ON), 1);
    chk("mid_hs", int'(VGA_HS), 1);
    chk("mid_vs", int'(VGA_VS), 1);
    chk("mid_rgb", int'(VGA_RGB), 0);
    release_check("rel2");

    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge CLK_IN);
      memRGB = 8'($urandom);
      RESET  = ($urandom_range(299) == 0);
    end
    RESET = 1'b0;
    repeat (5) @(negedge CLK_IN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
